mux_4_1_arb_v: RTL and testbench

Four-channel-to-one multiplexer with round-robin arbitration and a valid/ready handshake on every port. It merges four producer streams onto one consumer stream and is the collecting counterpart to the 1-to-4 demultiplexer. Each output beat carries a one-hot select code naming its source channel, in the same 4-bit one-hot format the demux consumes. This lets a downstream demux route the beat back.

---
 rtl/mux_pkg_v.sv | 26 ++
 rtl/rr_arb_4_v.sv | 42 ++++
 rtl/mux_4_1_arb_v.sv | 128 ++++++++++++
 tb/tb_mux_4_1_arb_v.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg_v.sv
// -----------------------------------------------------------------------------
// mux_pkg_v
// Shared definitions for the 4:1 round-robin mux and its 1:4 demux partner.
//   NUM_CH          : number of channels (4)
//   SEL_W           : width of the one-hot select code carried with each beat
//   state_t         : output-register FSM states (EMPTY / FULL)
//   onehot_from_idx : channel index -> one-hot select code
// -----------------------------------------------------------------------------
package mux_pkg_v;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] onehot_from_idx(input logic [1:0] idx);
    logic [SEL_W-1:0] code;
    code      = '0;
    code[idx] = 1'b1;
    return code;
  endfunction

endpackage

// File: rtl/rr_arb_4_v.sv
// -----------------------------------------------------------------------------
// rr_arb_4_v
// Combinational rotating-priority arbiter for four requesters. The channel at
// index ptr has the highest priority, then ptr+1, ptr+2, ptr+3 (mod 4).
// Ports:
//   req     in  [3:0] request vector, bit k = channel k
//   ptr     in  [1:0] highest-priority channel
//   gnt_idx out [1:0] index of the winning channel (meaningless if !gnt_vld)
//   gnt_vld out       at least one request is present
// -----------------------------------------------------------------------------
module rr_arb_4_v
  import mux_pkg_v::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  output logic [1:0]        gnt_idx,
  output logic              gnt_vld
);

  // Requests rotated so that position 0 is the channel at ptr.
  logic [NUM_CH-1:0] rot_req;
  logic [1:0]        offset;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr + 2'(gi)];
    end
  endgenerate

  // Scan from the lowest priority upward so the nearest request wins.
  always_comb begin
    offset = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot_req[i]) offset = 2'(i);
    end
  end

  assign gnt_vld = |req;
  assign gnt_idx = ptr + offset;

endmodule

// File: rtl/mux_4_1_arb_v.sv
// -----------------------------------------------------------------------------
// mux_4_1_arb_v
// Merges four valid/ready producer streams into one consumer stream with
// round-robin arbitration. Each output beat carries a one-hot code naming its
// source channel. A single output register gives one-cycle latency and, by
// loading on the same edge it drains, one beat per cycle throughput.
// Ports:
//   i_clk       in             clock
//   i_rst_n     in             asynchronous active-low reset
//   i_valid     in  [3:0]      per-channel valid
//   i_data      in  [4*WIDTH]  channel k data at [k*WIDTH +: WIDTH]
//   o_ready     out [3:0]      per-channel ready, only the granted channel
//   o_valid     out            output beat valid
//   o_data      out [WIDTH]    output beat data
//   o_sel_code  out [3:0]      one-hot source channel, 0 when o_valid=0
//   i_ready     in             downstream ready
// Optional feature, macro MUX_4_1_BEAT_CNT_EN:
//   i_cnt_clr   in             synchronous clear of all beat counters
//   o_beat_cnt  out [4*CNT_W]  saturating per-channel accepted-beat counters
// -----------------------------------------------------------------------------
module mux_4_1_arb_v
  import mux_pkg_v::*;
#(
  parameter int WIDTH = 8
`ifdef MUX_4_1_BEAT_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_CH-1:0]     i_valid,
  input  logic [NUM_CH*WIDTH-1:0] i_data,
  output logic [NUM_CH-1:0]     o_ready,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data,
  output logic [SEL_W-1:0]      o_sel_code,
  input  logic                  i_ready
`ifdef MUX_4_1_BEAT_CNT_EN
  , input  logic                i_cnt_clr,
  output logic [NUM_CH*CNT_W-1:0] o_beat_cnt
`endif
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg;
  logic [SEL_W-1:0] sel_reg;
  logic [1:0]       ptr_reg;

  logic [1:0]       gnt_idx;
  logic             gnt_vld;
  logic             ld;
  logic             take;
  logic [WIDTH-1:0] ch_data [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi] = i_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arb_4_v u_arb (
    .req     (i_valid),
    .ptr     (ptr_reg),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // The output register may accept a beat when it is empty or is being
  // drained on this very edge.
  assign ld   = (state_reg == EMPTY) | (o_valid & i_ready);
  assign take = ld & gnt_vld;

  // Gated by reset so no producer sees a handshake while the block is held.
  always_comb begin
    o_ready = '0;
    if (i_rst_n && take) o_ready = onehot_from_idx(gnt_idx);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= EMPTY;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (take)                    state_next = FULL;
    else if (o_valid && i_ready) state_next = EMPTY;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_reg <= '0;
      sel_reg  <= '0;
      ptr_reg  <= '0;
    end else if (take) begin
      data_reg <= ch_data[gnt_idx];
      sel_reg  <= onehot_from_idx(gnt_idx);
      ptr_reg  <= gnt_idx + 2'd1;
    end else if (o_valid && i_ready) begin
      // Drained with nothing behind it: data is left as-is, code cleared.
      sel_reg <= '0;
    end
  end

  assign o_valid    = (state_reg == FULL);
  assign o_data     = data_reg;
  assign o_sel_code = sel_reg;

`ifdef MUX_4_1_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt_reg [NUM_CH];

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
          cnt_reg[gi] <= '0;
        else if (i_cnt_clr)
          cnt_reg[gi] <= '0;
        else if (i_valid[gi] && o_ready[gi] && !(&cnt_reg[gi]))
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
      assign o_beat_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mux_4_1_arb_v.sv
// -----------------------------------------------------------------------------
// tb_mux_4_1_arb_v
// Self-checking bench for mux_4_1_arb_v: directed scenarios with literal
// expectations, then randomized producers that hold valid/data until accepted,
// all checked every cycle against a transaction-level model. Define
// MUX_4_1_BEAT_CNT_EN to also exercise the beat counters (CNT_W=2).
// -----------------------------------------------------------------------------
module tb_mux_4_1_arb_v;

  localparam int W  = 8;
`ifdef MUX_4_1_BEAT_CNT_EN
  localparam int CW = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_valid;
  logic [31:0] i_data;
  logic        i_ready;
  logic [3:0]  o_ready;
  logic        o_valid;
  logic [7:0]  o_data;
  logic [3:0]  o_sel_code;
`ifdef MUX_4_1_BEAT_CNT_EN
  logic        i_cnt_clr;
  logic [4*CW-1:0] o_beat_cnt;
`endif

  always #5 clk = ~clk;

  mux_4_1_arb_v #(
    .WIDTH (W)
`ifdef MUX_4_1_BEAT_CNT_EN
    , .CNT_W (CW)
`endif
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_sel_code (o_sel_code),
    .i_ready    (i_ready)
`ifdef MUX_4_1_BEAT_CNT_EN
    , .i_cnt_clr  (i_cnt_clr),
    .o_beat_cnt (o_beat_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level model of the output register.
  bit         m_valid = 0;
  logic [7:0] m_data  = '0;
  logic [3:0] m_sel   = '0;
  int         m_ptr   = 0;
  int         m_cnt [4] = '{0, 0, 0, 0};

  logic [3:0] seen_ready;
  int         acc_ch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
    chk("o_sel_code", {28'd0, o_sel_code}, {28'd0, m_sel});
    chk("o_data", {24'd0, o_data}, {24'd0, m_data});
`ifdef MUX_4_1_BEAT_CNT_EN
    for (int k = 0; k < 4; k++)
      chk("o_beat_cnt", 32'(o_beat_cnt[k*CW +: CW]), 32'(m_cnt[k]));
`endif
  endtask

  // One cycle: drive inputs just after a falling edge, check o_ready, then
  // advance the model across the rising edge and check registered outputs.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic r, input logic clr);
    int g;
    bit ld, take;
    logic [3:0] exp_rdy;
    i_valid = v;
    i_data  = d;
    i_ready = r;
`ifdef MUX_4_1_BEAT_CNT_EN
    i_cnt_clr = clr;
`endif
    #1;
    ld = !m_valid || r;
    g  = -1;
    for (int j = 0; j < 4; j++) begin
      int c;
      c = (m_ptr + j) % 4;
      if (g < 0 && v[c]) g = c;
    end
    take    = ld && (g >= 0);
    exp_rdy = take ? 4'(1 << g) : 4'd0;
    seen_ready = o_ready;
    chk("o_ready", {28'd0, o_ready}, {28'd0, exp_rdy});
    acc_ch = take ? g : -1;
    $display("cyc t=%0t v=%b r=%b grant=%0d ptr=%0d", $time, v, r, acc_ch, m_ptr);
    @(posedge clk);
    if (take) begin
      m_data  = d[g*8 +: 8];
      m_sel   = 4'(1 << g);
      m_valid = 1;
      m_ptr   = (g + 1) % 4;
    end else if (m_valid && r) begin
      m_valid = 0;
      m_sel   = '0;
    end
    for (int k = 0; k < 4; k++) begin
      if (clr) m_cnt[k] = 0;
      else if (take && g == k && m_cnt[k] < 3) m_cnt[k]++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Assert reset between edges, check outputs collapse at once, release later.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_sel", {28'd0, o_sel_code}, 32'd0);
    chk("rst_o_data", {24'd0, o_data}, 32'd0);
    chk("rst_o_ready", {28'd0, o_ready}, 32'd0);
    m_valid = 0; m_sel = '0; m_data = '0; m_ptr = 0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] rr_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  logic [3:0] rr_s [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  bit         pend_v [4];
  logic [7:0] pend_d [4];

  initial begin
    rst_n   = 1'b0;
    i_valid = 4'hF;
    i_data  = '0;
    i_ready = 1'b0;
`ifdef MUX_4_1_BEAT_CNT_EN
    i_cnt_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("init_o_valid", {31'd0, o_valid}, 32'd0);
    chk("init_o_data", {24'd0, o_data}, 32'd0);
    chk("init_o_sel", {28'd0, o_sel_code}, 32'd0);
    chk("init_o_ready", {28'd0, o_ready}, 32'd0);
    rst_n = 1'b1;

    // Single channel
    step(4'b0100, 32'h003C_0000, 1'b1, 1'b0);
    chk("single_ready", {28'd0, seen_ready}, 32'h4);
    chk("single_valid", {31'd0, o_valid}, 32'd1);
    chk("single_data", {24'd0, o_data}, 32'h3C);
    chk("single_sel", {28'd0, o_sel_code}, 32'h4);
    step(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("drain_valid", {31'd0, o_valid}, 32'd0);
    chk("drain_sel", {28'd0, o_sel_code}, 32'd0);

    // Reset mid-beat
    step(4'b0100, 32'h00A5_0000, 1'b0, 1'b0);
    chk("held_data", {24'd0, o_data}, 32'hA5);
    do_reset();

    // Round-robin from ptr=0 after reset
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 32'h1312_1110, 1'b1, 1'b0);
      chk("rr_data", {24'd0, o_data}, {24'd0, rr_d[i]});
      chk("rr_sel", {28'd0, o_sel_code}, {28'd0, rr_s[i]});
    end

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 32'h1312_1110, 1'b0, 1'b0);
      chk("bp_ready", {28'd0, seen_ready}, 32'd0);
      chk("bp_data", {24'd0, o_data}, 32'h10);
      chk("bp_sel", {28'd0, o_sel_code}, 32'h1);
    end
    step(4'hF, 32'h1312_1110, 1'b1, 1'b0);
    chk("bp_rel_valid", {31'd0, o_valid}, 32'd1);
    chk("bp_rel_data", {24'd0, o_data}, 32'h11);
    chk("bp_rel_sel", {28'd0, o_sel_code}, 32'h2);

    // Wrap / skip: ptr=2 -> grant 2 -> ptr=3
    step(4'b0100, 32'h0022_0000, 1'b1, 1'b0);
    chk("wrap_sel2", {28'd0, o_sel_code}, 32'h4);
    step(4'b0010, 32'h0000_3300, 1'b1, 1'b0);
    chk("wrap_sel1", {28'd0, o_sel_code}, 32'h2);
    chk("wrap_data1", {24'd0, o_data}, 32'h33);
    step(4'b1001, 32'h4400_0055, 1'b1, 1'b0);
    chk("wrap_sel3", {28'd0, o_sel_code}, 32'h8);
    chk("wrap_data3", {24'd0, o_data}, 32'h44);
    step(4'b1001, 32'h4400_0055, 1'b1, 1'b0);
    chk("wrap_sel0", {28'd0, o_sel_code}, 32'h1);
    step(4'b0000, 32'h0, 1'b1, 1'b0);

`ifdef MUX_4_1_BEAT_CNT_EN
    step(4'b0000, 32'h0, 1'b1, 1'b1);
    chk("cnt_clr", 32'(o_beat_cnt), 32'd0);
    for (int i = 0; i < 5; i++) step(4'b0010, 32'h0000_0700, 1'b1, 1'b0);
    chk("cnt_sat", 32'(o_beat_cnt[CW +: CW]), 32'd3);
    step(4'b0010, 32'h0000_0700, 1'b1, 1'b1);
    chk("cnt_clr_wins", 32'(o_beat_cnt[CW +: CW]), 32'd0);
`endif

    // Randomized producers holding valid/data until accepted.
    for (int k = 0; k < 4; k++) pend_v[k] = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  v;
      logic [31:0] d;
      for (int k = 0; k < 4; k++) begin
        if (!pend_v[k] && ($urandom % 2 == 0)) begin
          pend_v[k] = 1;
          pend_d[k] = 8'($urandom);
        end
        v[k] = pend_v[k];
        d[k*8 +: 8] = pend_d[k];
      end
      step(v, d, ($urandom % 4) != 0, ($urandom % 64) == 0);
      if (acc_ch >= 0) pend_v[acc_ch] = 0;
      if (n % 700 == 699) begin
        do_reset();
        for (int k = 0; k < 4; k++) pend_v[k] = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
